// File: rtl/led_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_sched
// Brief    : Debounced-switch LED pattern sequencer (walk/rotate/toggle) with
//            an internal step-tick generator on a single clock.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_sched #(
    parameter int DEB_CNT = 50000,
    parameter int CNT_W   = 23,
    parameter int PERIOD0 = 1000000,
    parameter int PERIOD1 = 1500000,
    parameter int PERIOD2 = 2500000,
    parameter int PERIOD3 = 5000000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [3:0] sw,
    output logic [3:0] led,
    output logic       tick,
    output logic [1:0] mode,
    output logic       busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;

    localparam logic [1:0] c_mode_walk   = 2'b00;
    localparam logic [1:0] c_mode_rotate = 2'b01;
    localparam logic [1:0] c_mode_toggle = 2'b10;

    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] c_per_last0 = CNT_W'(PERIOD0 - 1);
    localparam logic [CNT_W-1:0] c_per_last1 = CNT_W'(PERIOD1 - 1);
    localparam logic [CNT_W-1:0] c_per_last2 = CNT_W'(PERIOD2 - 1);
    localparam logic [CNT_W-1:0] c_per_last3 = CNT_W'(PERIOD3 - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       w_deb;
    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic [1:0]       r_speed;
    logic [1:0]       r_walk_idx;
    logic [3:0]       r_led;
    logic [3:0]       r_mask;
    logic             r_tick;
    logic             r_busy;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [1:0]       w_mode_dec;
    logic [1:0]       w_speed;
    logic [1:0]       w_walk_next;
    logic [CNT_W-1:0] w_per_last;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // A bit is accepted only after DEB_CNT consecutive differing samples.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_deb
            logic [CNT_W-1:0] r_cnt;
            logic             r_bit;
            always_ff @(posedge clk_in) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_bit <= 1'b0;
                end else if (r_sync2[gi] == r_bit) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_last) begin
                    r_bit <= r_sync2[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
            assign w_deb[gi] = r_bit;
        end
    endgenerate

    assign w_mode_dec  = w_deb[0] ? c_mode_rotate :
                         w_deb[1] ? c_mode_toggle : c_mode_walk;
    assign w_speed     = w_deb[3:2];
    assign w_walk_next = r_walk_idx + 2'd1;

    always_comb begin
        w_per_last = c_per_last0;
        case (w_speed)
            2'b01:   w_per_last = c_per_last1;
            2'b10:   w_per_last = c_per_last2;
            2'b11:   w_per_last = c_per_last3;
            default: w_per_last = c_per_last0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_idle_cnt <= '0;
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
            r_led      <= 4'b0000;
            r_mode     <= c_mode_walk;
            r_busy     <= 1'b0;
            r_speed    <= 2'b00;
            r_walk_idx <= 2'd0;
            r_mask     <= 4'b1000;
        end else begin
            r_speed <= w_speed;
            r_tick  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_tick_cnt <= '0;
                    if (r_idle_cnt == c_deb_last) begin
                        r_idle_cnt <= '0;
                        r_state    <= c_st_load;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + c_cnt_one;
                    end
                end
                c_st_load: begin
                    r_mode     <= w_mode_dec;
                    r_led      <= (w_mode_dec == c_mode_toggle) ? 4'b0000 : 4'b0001;
                    r_walk_idx <= 2'd0;
                    r_mask     <= 4'b1000;
                    r_tick_cnt <= '0;
                    r_busy     <= 1'b1;
                    r_state    <= c_st_run;
                end
                c_st_run: begin
                    // A mode change wins over both a speed change and a due tick.
                    if (w_mode_dec != r_mode) begin
                        r_tick_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= c_st_load;
                    end else if (w_speed != r_speed) begin
                        r_tick_cnt <= '0;
                    end else if (r_tick_cnt == w_per_last) begin
                        r_tick_cnt <= '0;
                        r_tick     <= 1'b1;
                        case (r_mode)
                            c_mode_rotate: r_led <= {r_led[0], r_led[3:1]};
                            c_mode_toggle: begin
                                r_led  <= r_led ^ r_mask;
                                r_mask <= {r_mask[0], r_mask[3:1]};
                            end
                            default: begin
                                r_led      <= 4'b0001 << w_walk_next;
                                r_walk_idx <= w_walk_next;
                            end
                        endcase
                    end else begin
                        r_tick_cnt <= r_tick_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign led  = r_led;
    assign tick = r_tick;
    assign mode = r_mode;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_sched
// Brief    : Self-checking bench for led_pattern_sched against a step-count
//            based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_sched;

    localparam int c_deb = 4;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] sw     = 4'b0000;
    logic [3:0] led;
    logic       tick;
    logic [1:0] mode;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    int         m_phase     = 0;   // 0 idle, 1 load, 2 run
    int         m_idle_left = c_deb;
    logic [3:0] m_deb       = 4'b0000;
    logic [3:0] m_h0        = 4'b0000;
    logic [3:0] m_h1        = 4'b0000;
    int         m_runlen [4];
    int         m_elapsed   = 0;
    int         m_steps     = 0;
    logic [1:0] m_prev_spd  = 2'b00;
    logic [3:0] m_led       = 4'b0000;
    logic       m_tick      = 1'b0;
    logic [1:0] m_mode      = 2'b00;

    led_pattern_sched #(
        .DEB_CNT(c_deb), .CNT_W(23),
        .PERIOD0(4), .PERIOD1(6), .PERIOD2(8), .PERIOD3(10)
    ) dut (
        .clk_in(clk_in), .rst(rst), .sw(sw),
        .led(led), .tick(tick), .mode(mode), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    function automatic int period_of(logic [1:0] spd);
        case (spd)
            2'b00:   return 4;
            2'b01:   return 6;
            2'b10:   return 8;
            default: return 10;
        endcase
    endfunction

    function automatic logic [1:0] mode_of(logic [3:0] d);
        if (d[0]) return 2'b01;
        if (d[1]) return 2'b10;
        return 2'b00;
    endfunction

    // LED value after k steps from the mode's starting pattern
    function automatic logic [3:0] led_of(logic [1:0] md, int k);
        int j;
        case (md)
            2'b01: return 4'b0001 << ((4 - (k % 4)) % 4);
            2'b10: begin
                j = k % 8;
                if (j <= 4) return 4'hF << (4 - j);
                return 4'((1 << (8 - j)) - 1);
            end
            default: return 4'b0001 << (k % 4);
        endcase
    endfunction

    function automatic logic [7:0] obs();
        return {led, tick, mode, busy};
    endfunction

    function automatic logic [7:0] expv();
        return {m_led, m_tick, m_mode, (m_phase == 2)};
    endfunction

    task automatic model_edge();
        logic [1:0] dec;
        logic [1:0] spd;
        if (rst) begin
            m_phase = 0; m_idle_left = c_deb; m_deb = '0; m_h0 = '0; m_h1 = '0;
            m_elapsed = 0; m_steps = 0; m_prev_spd = '0; m_led = '0; m_tick = 0; m_mode = '0;
            for (int b = 0; b < 4; b++) m_runlen[b] = 0;
            return;
        end
        dec    = mode_of(m_deb);
        spd    = m_deb[3:2];
        m_tick = 1'b0;
        case (m_phase)
            0: begin
                m_idle_left--;
                if (m_idle_left == 0) m_phase = 1;
            end
            1: begin
                m_mode = dec; m_steps = 0; m_elapsed = 0;
                m_led = led_of(dec, 0); m_phase = 2;
            end
            default: begin
                if (dec != m_mode) m_phase = 1;
                else if (spd != m_prev_spd) m_elapsed = 0;
                else begin
                    m_elapsed++;
                    if (m_elapsed == period_of(spd)) begin
                        m_elapsed = 0; m_tick = 1'b1; m_steps++;
                        m_led = led_of(m_mode, m_steps);
                    end
                end
            end
        endcase
        m_prev_spd = spd;
        for (int b = 0; b < 4; b++) begin
            if (m_h1[b] !== m_deb[b]) begin
                m_runlen[b]++;
                if (m_runlen[b] == c_deb) begin
                    m_deb[b] = m_h1[b];
                    m_runlen[b] = 0;
                end
            end else begin
                m_runlen[b] = 0;
            end
        end
        m_h1 = m_h0;
        m_h0 = sw;
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [3:0] seq [4];
        int nt;
        seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
        rst = 1'b1; sw = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        checks++;
        if (obs() !== 8'h00) begin errors++; $display("FAIL reset_values got=%b exp=%b", obs(), 8'h00); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL idle_seq cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            if (i < 4) begin
                checks++;
                if (led !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL idle_outputs cyc=%0d got led=%b busy=%b exp led=0000 busy=0", cyc, led, busy); end
            end
        end
        checks++;
        if (led !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL load_walk got led=%b busy=%b exp led=0001 busy=1", led, busy); end
        nt = 0;
        for (int i = 0; i < 40 && nt < 4; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL walk_run cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            if (tick === 1'b1) begin
                checks++;
                if (led !== seq[nt]) begin errors++; $display("FAIL walk_step%0d got=%b exp=%b", nt, led, seq[nt]); end
                nt++;
            end
        end
        checks++;
        if (nt != 4) begin errors++; $display("FAIL walk_tick_count got=%0d exp=4", nt); end
    endtask

    task automatic test_glitch();
        sw = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL glitch_pulse cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        sw = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL glitch_after cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        checks++;
        if (mode !== 2'b00) begin errors++; $display("FAIL glitch_mode got=%b exp=00", mode); end
        sw = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL rotate_entry cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        checks++;
        if (mode !== 2'b01) begin errors++; $display("FAIL rotate_mode got=%b exp=01", mode); end
    endtask

    task automatic test_toggle();
        logic [3:0] tbl [8];
        int ti;
        tbl[0] = 4'b1000; tbl[1] = 4'b1100; tbl[2] = 4'b1110; tbl[3] = 4'b1111;
        tbl[4] = 4'b0111; tbl[5] = 4'b0011; tbl[6] = 4'b0001; tbl[7] = 4'b0000;
        ti = 0;
        sw = 4'b0010;
        for (int i = 0; i < 60; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL toggle_run cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            if (tick === 1'b1 && mode === 2'b10 && ti < 8) begin
                checks++;
                if (led !== tbl[ti]) begin errors++; $display("FAIL toggle_step%0d got=%b exp=%b", ti, led, tbl[ti]); end
                ti++;
            end
        end
        checks++;
        if (ti != 8) begin errors++; $display("FAIL toggle_tick_count got=%0d exp=8", ti); end
    endtask

    task automatic test_speed();
        int t_prev, t_last, nt, drops;
        t_prev = 0; t_last = 0; nt = 0; drops = 0;
        sw = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL speed_settle cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
        sw = 4'b1100;
        for (int i = 0; i < 50; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL speed_run cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            if (busy !== 1'b1) drops++;
            if (tick === 1'b1) begin t_prev = t_last; t_last = cyc; nt++; end
        end
        checks++;
        if (drops != 0 || mode !== 2'b00) begin errors++; $display("FAIL speed_no_reload got drops=%0d mode=%b exp drops=0 mode=00", drops, mode); end
        checks++;
        if (nt < 3 || (t_last - t_prev) != 10) begin errors++; $display("FAIL speed_period got ticks=%0d gap=%0d exp gap=10", nt, t_last - t_prev); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] led_hold;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_phase == 2 && m_elapsed == 3 && m_mode == 2'b00 && m_deb == 4'b1100 && m_h1 == 4'b1100)
                found = 1'b1;
            else begin
                cycle(); checks++;
                if (obs() !== expv()) begin errors++; $display("FAIL sim_align cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL sim_window got=none exp=aligned"); end
        if (found) begin
            led_hold = m_led;
            sw = 4'b1101;
            for (int i = 0; i < 6; i++) begin
                cycle(); checks++;
                if (obs() !== expv()) begin errors++; $display("FAIL sim_debounce cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            end
            cycle(); checks++;
            if (tick !== 1'b0 || busy !== 1'b0 || led !== led_hold) begin
                errors++; $display("FAIL sim_discard got tick=%b busy=%b led=%b exp tick=0 busy=0 led=%b", tick, busy, led, led_hold);
            end
            cycle(); checks++;
            if (led !== 4'b0001 || busy !== 1'b1 || mode !== 2'b01) begin
                errors++; $display("FAIL sim_load got led=%b busy=%b mode=%b exp led=0001 busy=1 mode=01", led, busy, mode);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        sw = 4'b0010;
        for (int i = 0; i < 80 && !found; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL mid_run cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
            if (mode === 2'b10 && led === 4'b1110) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_reach got=timeout exp=led1110"); end
        rst = 1'b1;
        cycle(); checks++;
        if (obs() !== 8'h00) begin errors++; $display("FAIL mid_reset got=%b exp=%b", obs(), 8'h00); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(); checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL mid_restart cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
        end
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 120; k++) begin
            sw = 4'($urandom);
            if ($urandom_range(0, 49) == 0) rst = 1'b1;
            n = $urandom_range(1, 25);
            for (int j = 0; j < n; j++) begin
                cycle(); checks++;
                if (obs() !== expv()) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), expv()); end
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        for (int b = 0; b < 4; b++) m_runlen[b] = 0;
        test_reset();
        test_glitch();
        test_toggle();
        test_speed();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
